// File: rtl/lt_seq_pkg.sv
// Shared definitions for bit-serial sequencers: FSM state encoding and the
// borrow-cell implementation selectors.
package lt_seq_pkg;

    // Sequencer states; the encodings are fixed so other bit-serial blocks
    // can decode them directly.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } seq_state_e;

    // Borrow-cell implementation styles.
    localparam int unsigned ImplExpr = 0;  // sum-of-products equation
    localparam int unsigned ImplMux  = 1;  // a^b selects b or borrow_in

    // Bit-counter width for an operand of `width` bits (never below 1).
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/subtractor_1bit_cmp.sv
// One-bit borrow cell for a serial a - b comparison. Computes the borrow out
// of a single bit position given the incoming borrow.
module subtractor_1bit_cmp
    import lt_seq_pkg::*;
#(
    parameter int unsigned IMPL_TYPE = ImplExpr
) (
    input  logic a,
    input  logic b,
    input  logic borrow_in,
    output logic borrow_out
);

    if (IMPL_TYPE == ImplMux) begin : g_mux
        // Differing bits decide the borrow (it equals b); equal bits pass it on.
        always_comb begin
            borrow_out = (a ^ b) ? b : borrow_in;
        end
    end else begin : g_expr
        // Borrow equation: generate on ~a&b, propagate when bits are equal.
        always_comb begin
            borrow_out = (~a & b) | (~(a ^ b) & borrow_in);
        end
    end

endmodule

// File: rtl/lt_int_seq.sv
// Bit-serial signed less-than comparator. Accepts an operand pair, walks the
// bits LSB first through a single borrow cell and reports Y = (A < B) signed.
// The sign bit is handled by swapping the cell inputs, which turns the
// unsigned borrow chain into a signed comparison.
module lt_int_seq
    import lt_seq_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned IMPL_TYPE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             Y,
    output logic             busy
);

    localparam int unsigned CntW = cnt_width(WIDTH);
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    seq_state_e       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             borrow_q, borrow_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             y_q, y_d;

    logic is_sign;
    logic cell_a;
    logic cell_b;
    logic cell_borrow;

    // Feed the shared cell from the shift-register LSBs; swap them on the sign bit.
    always_comb begin
        is_sign = (cnt_q == LastBit);
        cell_a  = is_sign ? b_q[0] : a_q[0];
        cell_b  = is_sign ? a_q[0] : b_q[0];
    end

    subtractor_1bit_cmp #(
        .IMPL_TYPE (IMPL_TYPE)
    ) u_cell (
        .a          (cell_a),
        .b          (cell_b),
        .borrow_in  (borrow_q),
        .borrow_out (cell_borrow)
    );

    // Next-state logic: accept in IDLE, shift one bit per cycle in RUN, hold in DONE.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        y_d      = y_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d      = A;
                    b_d      = B;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = StRun;
                end
            end
            StRun: begin
                a_d      = {1'b0, a_q[WIDTH-1:1]};
                b_d      = {1'b0, b_q[WIDTH-1:1]};
                borrow_d = cell_borrow;
                if (is_sign) begin
                    // Counter stays on the last bit so it never wraps.
                    y_d     = cell_borrow;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            y_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
            y_q      <= y_d;
        end
    end

    // Handshake and status outputs decode straight from the state register.
    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
        busy      = (state_q != StIdle);
        Y         = y_q;
    end

endmodule

// File: tb/tb_lt_int_seq.sv
// Bench for lt_int_seq: three instances (WIDTH 8, 2, 16) on a shared clock and
// reset. A negedge monitor pushes the expected result of every accepted pair
// and pops/compares it when the result handshakes.
module tb_lt_int_seq;

    localparam int NLanes = 3;
    localparam int LW [NLanes] = '{8, 2, 16};

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        in_valid  [NLanes];
    logic        in_ready  [NLanes];
    logic        out_valid [NLanes];
    logic        out_ready [NLanes];
    logic        y         [NLanes];
    logic        busy      [NLanes];
    logic [15:0] a_in      [NLanes];
    logic [15:0] b_in      [NLanes];

    longint cyc = 0;
    int     n_cmp = 0;
    int     n_err = 0;

    bit     exp_q  [NLanes][$];
    longint acc_q  [NLanes][$];
    bit     b2b       [NLanes];
    bit     prev_b2b  [NLanes];
    bit     have_prev [NLanes];
    bit     prev_ov   [NLanes];
    longint prev_acc  [NLanes];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NLanes; g++) begin : g_lane
        lt_int_seq #(
            .WIDTH     (LW[g]),
            .IMPL_TYPE (g % 2)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .A         (a_in[g][LW[g]-1:0]),
            .B         (b_in[g][LW[g]-1:0]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .Y         (y[g]),
            .busy      (busy[g])
        );
    end

    // Signed w-bit compare: move the operand to the top of a 64-bit signed word.
    function automatic bit lt_ref(input logic [15:0] a, input logic [15:0] b, input int w);
        longint sa;
        longint sb;
        sa = longint'({48'd0, a}) << (64 - w);
        sb = longint'({48'd0, b}) << (64 - w);
        return sa < sb;
    endfunction

    task automatic check(input string name, input int l, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s lane=%0d (width %0d) t=%0t: got %0d, expected %0d",
                     name, l, LW[l], $time, act, exp);
        end
    endtask

    task automatic fail_note(input string name, input int l);
        n_cmp++;
        n_err++;
        $display("FAIL %s lane=%0d (width %0d) t=%0t: got timeout/unexpected event, expected none",
                 name, l, LW[l], $time);
    endtask

    // Monitor: accepts push expectations, result handshakes pop and compare.
    initial begin
        forever begin
            @(negedge clk);
            for (int l = 0; l < NLanes; l++) begin
                if (!rst_n) begin
                    exp_q[l].delete();
                    acc_q[l].delete();
                    have_prev[l] = 1'b0;
                    prev_ov[l]   = 1'b0;
                end else begin
                    if (out_valid[l] && !prev_ov[l]) begin
                        if (acc_q[l].size() == 0) fail_note("spurious_valid", l);
                        else check("valid_latency", l, cyc - acc_q[l][0], LW[l] + 1);
                    end
                    if (out_valid[l] && out_ready[l]) begin
                        if (exp_q[l].size() == 0) begin
                            fail_note("unexpected_result", l);
                        end else begin
                            check("y_result", l, y[l], exp_q[l].pop_front());
                            void'(acc_q[l].pop_front());
                        end
                    end
                    if (in_valid[l] && in_ready[l]) begin
                        exp_q[l].push_back(lt_ref(a_in[l], b_in[l], LW[l]));
                        acc_q[l].push_back(cyc);
                        if (b2b[l] && have_prev[l] && prev_b2b[l])
                            check("issue_interval", l, cyc - prev_acc[l], LW[l] + 2);
                        prev_acc[l]  = cyc;
                        have_prev[l] = 1'b1;
                        prev_b2b[l]  = b2b[l];
                    end
                    prev_ov[l] = out_valid[l];
                end
            end
        end
    end

    // Returns at posedge+1 just after the accepting edge.
    task automatic wait_accept(input int l, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (in_valid[l] && in_ready[l] && rst_n) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_note("accept_timeout", l);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_result(input int l);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (out_valid[l] && out_ready[l]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_note("result_timeout", l);
        @(posedge clk);
        #1;
    endtask

    // Issue one pair, then scramble A/B so late changes would corrupt a bad design.
    task automatic issue(input int l, input logic [15:0] a, input logic [15:0] b);
        bit ok;
        a_in[l]     = a;
        b_in[l]     = b;
        in_valid[l] = 1'b1;
        wait_accept(l, ok);
        in_valid[l] = 1'b0;
        a_in[l]     = 16'($urandom);
        b_in[l]     = 16'($urandom);
    endtask

    // Back-to-back random pairs with out_ready held high.
    task automatic run_rand(input int l, input int n);
        bit ok;
        b2b[l]       = 1'b1;
        out_ready[l] = 1'b1;
        in_valid[l]  = 1'b1;
        for (int i = 0; i < n; i++) begin
            a_in[l] = 16'($urandom);
            b_in[l] = 16'($urandom);
            if ($urandom_range(0, 4) == 0) b_in[l] = a_in[l];
            wait_accept(l, ok);
            if (!ok) break;
        end
        in_valid[l] = 1'b0;
        b2b[l]      = 1'b0;
        for (int i = 0; i < 64 && exp_q[l].size() != 0; i++) @(negedge clk);
        check("drain", l, exp_q[l].size(), 0);
    endtask

    logic [7:0] dir_a [6];
    logic [7:0] dir_b [6];
    longint     c0;
    bit         seen;

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t: got no finish, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        dir_a = '{8'h80, 8'h05, 8'hFF, 8'h00, 8'hFE, 8'h7F};
        dir_b = '{8'h7F, 8'h05, 8'h00, 8'hFF, 8'hFF, 8'h80};
        for (int l = 0; l < NLanes; l++) begin
            in_valid[l]  = 1'b1;  // reset must override a pending handshake
            out_ready[l] = 1'b1;
            a_in[l]      = 16'h0001;
            b_in[l]      = 16'h0002;
            b2b[l]       = 1'b0;
        end

        // Reset state.
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int l = 0; l < NLanes; l++) begin
            check("rst_in_ready", l, in_ready[l], 1);
            check("rst_out_valid", l, out_valid[l], 0);
            check("rst_y", l, y[l], 0);
            check("rst_busy", l, busy[l], 0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int l = 0; l < NLanes; l++) in_valid[l] = 1'b0;

        // Directed vectors on the 8-bit lane.
        for (int i = 0; i < 6; i++) begin
            issue(0, {8'd0, dir_a[i]}, {8'd0, dir_b[i]});
            wait_result(0);
        end

        // Stall in DONE with a pending request.
        out_ready[0] = 1'b0;
        issue(0, 16'h00FD, 16'h0003);
        seen = 1'b0;
        for (int i = 0; i < 64 && !seen; i++) begin
            @(negedge clk);
            seen = out_valid[0];
        end
        if (!seen) fail_note("stall_valid_timeout", 0);
        @(posedge clk);
        #1;
        a_in[0]     = 16'h0040;
        b_in[0]     = 16'h00C0;
        in_valid[0] = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("stall_out_valid", 0, out_valid[0], 1);
            check("stall_in_ready", 0, in_ready[0], 0);
            if (exp_q[0].size() == 0) fail_note("stall_no_expect", 0);
            else check("stall_y", 0, y[0], exp_q[0][0]);
        end
        @(posedge clk);
        #1;
        out_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[0] = 1'b0;
        @(negedge clk);
        check("release_in_ready", 0, in_ready[0], 1);
        check("release_out_valid", 0, out_valid[0], 0);
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        @(negedge clk);
        check("pending_accepted", 0, busy[0], 1);
        out_ready[0] = 1'b1;
        wait_result(0);

        // Reset during RUN after a Y=1 result.
        issue(0, 16'h0080, 16'h007F);
        wait_result(0);
        issue(0, 16'h0010, 16'h0020);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_in_ready", 0, in_ready[0], 1);
        check("abort_out_valid", 0, out_valid[0], 0);
        check("abort_y", 0, y[0], 0);
        check("abort_busy", 0, busy[0], 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        c0 = cyc;
        issue(0, 16'h00F0, 16'h0011);
        check("first_accept_edge", 0, cyc - c0, 1);
        wait_result(0);

        // Back-to-back random traffic on all widths.
        fork
            run_rand(0, 40);
            run_rand(1, 60);
            run_rand(2, 30);
        join

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lt_int_seq.md
LT_INT_SEQ -- requirements
Module: lt_int_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal range 2..64.
REQ-002 The block SHALL have parameter IMPL_TYPE, default 0, passed unchanged to the bit-cell sub-module.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the operand pair on A/B is valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts a new operand pair.
REQ-007 The block SHALL have port A, input, WIDTH bits: signed two's-complement operand A.
REQ-008 The block SHALL have port B, input, WIDTH bits: signed two's-complement operand B.
REQ-009 The block SHALL have port out_valid, output, 1 bit: Y holds a completed result.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-011 The block SHALL have port Y, output, 1 bit: the result, 1 iff signed A < signed B.
REQ-012 The block SHALL have port busy, output, 1 bit: high in RUN and DONE.

Function
REQ-013 The block SHALL be a three-state FSM: IDLE, RUN, DONE.
REQ-014 in_ready SHALL be 1 exactly in IDLE; an accept occurs when in_valid and in_ready are both 1 on a clock edge.
REQ-015 On accept, the block SHALL latch A and B into shift registers, clear borrow to 0, clear the bit counter to 0 and enter RUN.
REQ-016 In RUN, each cycle SHALL process one bit, LSB first, through one shared 1-bit borrow cell.
REQ-017 For bits 0..WIDTH-2: borrow_next = (~a & b) | (~(a ^ b) & borrow).
REQ-018 For bit WIDTH-1 (sign): borrow_next = (a & ~b) | (~(a ^ b) & borrow), i.e. the operands are swapped in the cell.
REQ-019 After the sign-bit cycle, the block SHALL load Y with borrow_next, set out_valid to 1 and enter DONE.
REQ-020 out_valid SHALL first be 1 exactly WIDTH+1 cycles after the accept edge (9 for WIDTH=8).
REQ-021 In DONE, Y and out_valid SHALL hold until an edge with out_ready=1, which returns the block to IDLE with out_valid=0.
REQ-022 in_valid SHALL be ignored outside IDLE, and changes on A/B after accept SHALL NOT affect the result.
REQ-023 Minimum issue interval SHALL be WIDTH+2 cycles with out_ready held at 1.
REQ-024 The bit counter SHALL be $clog2(WIDTH) bits wide and SHALL NOT wrap within one operation.
REQ-025 Y SHALL hold its last value outside DONE; only out_valid qualifies it.

Reset
REQ-026 When rst_n=0 at a clock edge, the block SHALL set: state=IDLE, in_ready=1, out_valid=0, Y=0, busy=0, borrow=0, counter=0.
REQ-027 Reset SHALL override any handshake on the same edge and SHALL abort an operation in RUN or DONE without producing a result.
REQ-028 The first accept SHALL be possible on the first edge after rst_n returns to 1.

Structure
REQ-029 The state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) SHALL live in shared package lt_seq_pkg for reuse by other bit-serial sequencers.
REQ-030 The borrow cell SHALL be a single instance of subtractor_1bit_cmp, with inputs a, b, borrow_in and output borrow_out.
REQ-031 The sign-bit swap SHALL be done by muxing the cell's inputs, not by adding a second cell.

Verification
REQ-032 WIDTH=8, A=8'h80, B=8'h7F, out_ready=1 -> out_valid=1 at cycle 9 after accept, Y=1.
REQ-033 A=8'h05, B=8'h05 -> Y=0; A=8'hFF, B=8'h00 -> Y=1; A=8'h00, B=8'hFF -> Y=0; A=8'hFE, B=8'hFF -> Y=1.
REQ-034 Hold out_ready=0 for 5 cycles in DONE -> Y and out_valid stable, in_ready=0, a pending in_valid not accepted; accept occurs on the edge after the out_ready pulse returns to IDLE.
REQ-035 Assert rst_n=0 at RUN cycle 4 -> next edge all outputs at reset values; a new operation then completes correctly.
REQ-036 Back-to-back random pairs with out_ready=1 -> issue interval exactly 10 cycles and every Y matches $signed(A)<$signed(B); repeat at WIDTH=2 and WIDTH=16.
